// File: rtl/ibex_ascon_defines.sv
// Shared ASCON definitions: state layout, round constants, rotation amounts,
// permutation FSM states and small helpers.
// Word i (x0..x4) lives in register pairs x12/13, x14/15, x16/17, x28/29, x30/31;
// bits 63:32 sit in reg_view.x_hi[i], bits 31:0 in reg_view.x_low[i].
package ibex_ascon_defines;

  localparam int unsigned AsconNumWords  = 5;
  localparam int unsigned AsconMaxRounds = 12;

  typedef struct packed {
    logic [AsconNumWords-1:0][31:0] x_hi;
    logic [AsconNumWords-1:0][31:0] x_low;
  } ascon_reg_view_t;

  typedef struct packed {
    ascon_reg_view_t reg_view;
  } ascon_state_t;

  typedef enum logic [1:0] {
    AsconIdle = 2'd0,
    AsconRun  = 2'd1,
    AsconWb   = 2'd2
  } ascon_perm_state_e;

  // Element [0] is c[0] = 0xf0, element [11] is c[11] = 0x4b.
  localparam logic [11:0][7:0] AsconRoundConst = {
    8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96,
    8'ha5, 8'hb4, 8'hc3, 8'hd2, 8'he1, 8'hf0
  };

  // Rotate-right amount pairs of the linear layer, indexed by word.
  localparam logic [4:0][5:0] AsconRotA = {6'd7,  6'd10, 6'd1, 6'd61, 6'd19};
  localparam logic [4:0][5:0] AsconRotB = {6'd41, 6'd17, 6'd6, 6'd39, 6'd28};

  // Out-of-range indices return 0 so an unused lookahead index is harmless.
  function automatic logic [7:0] ascon_round_const(input logic [3:0] idx);
    logic [7:0] rc;
    rc = 8'h00;
    if (idx < 4'd12) rc = AsconRoundConst[idx];
    return rc;
  endfunction

  function automatic logic [63:0] ascon_ror(input logic [63:0] x, input logic [5:0] amt);
    return (x >> amt) | (x << (7'd64 - {1'b0, amt}));
  endfunction

endpackage

// File: rtl/ibex_ascon_round.sv
// One combinational ASCON round: constant addition, bitsliced S-box, linear layer.
module ibex_ascon_round
  import ibex_ascon_defines::*;
(
  input  ascon_state_t state_i,
  input  logic [7:0]   const_i,
  output ascon_state_t state_o
);

  logic [4:0][63:0] a;
  logic [4:0][63:0] t;
  logic [4:0][63:0] b;
  logic [4:0][63:0] y;

  // Unpack the words, run the three round steps, and repack into register view.
  always_comb begin
    a = '0;
    t = '0;
    b = '0;
    y = '0;
    state_o = '0;
    for (int i = 0; i < 5; i++) begin
      a[i] = {state_i.reg_view.x_hi[i], state_i.reg_view.x_low[i]};
    end
    a[2] = a[2] ^ {56'h0, const_i};
    a[0] = a[0] ^ a[4];
    a[4] = a[4] ^ a[3];
    a[2] = a[2] ^ a[1];
    for (int i = 0; i < 5; i++) begin
      t[i] = ~a[i] & a[(i + 1) % 5];
    end
    for (int i = 0; i < 5; i++) begin
      b[i] = a[i] ^ t[(i + 1) % 5];
    end
    b[1] = b[1] ^ b[0];
    b[0] = b[0] ^ b[4];
    b[3] = b[3] ^ b[2];
    b[2] = ~b[2];
    for (int i = 0; i < 5; i++) begin
      y[i] = b[i] ^ ascon_ror(b[i], AsconRotA[i]) ^ ascon_ror(b[i], AsconRotB[i]);
      state_o.reg_view.x_hi[i]  = y[i][63:32];
      state_o.reg_view.x_low[i] = y[i][31:0];
    end
  end

endmodule

// File: rtl/ibex_ascon_perm_unit.sv
// Sequential ASCON permutation engine beside the ALU. Captures the register-file
// ASCON state, runs 1..12 rounds (c[12-n]..c[11]) and writes back with a single
// update strobe. Optional build macro ASCON_PERM_UNROLL2_EN chains two rounds
// per cycle; the result is identical either way.
module ibex_ascon_perm_unit
  import ibex_ascon_defines::*;
#(
  parameter int unsigned DefaultRounds = 12
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [3:0]   rounds_i,
  input  logic         abort_i,
  input  ascon_state_t state_i,
  output ascon_state_t state_o,
  output logic         we_update_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [3:0] DefaultRoundsW = 4'(DefaultRounds);

  ascon_perm_state_e fsm_q;
  ascon_state_t      state_q;
  ascon_state_t      state_d;
  ascon_state_t      roundOne;
  logic [3:0]        round_q;
  logic [3:0]        round_d;
  logic [3:0]        roundsEff;
  logic [3:0]        startRound;

  // Map the requested round count: 0 means the default, anything above 12 clamps.
  always_comb begin
    roundsEff = rounds_i;
    if (rounds_i == 4'd0) begin
      roundsEff = DefaultRoundsW;
    end else if (rounds_i > 4'd12) begin
      roundsEff = 4'd12;
    end
    startRound = 4'd12 - roundsEff;
  end

  ibex_ascon_round u_round0 (
    .state_i (state_q),
    .const_i (ascon_round_const(round_q)),
    .state_o (roundOne)
  );

`ifdef ASCON_PERM_UNROLL2_EN
  ascon_state_t roundTwo;

  ibex_ascon_round u_round1 (
    .state_i (roundOne),
    .const_i (ascon_round_const(round_q + 4'd1)),
    .state_o (roundTwo)
  );

  // Take two rounds while at least two remain, otherwise finish with one.
  always_comb begin
    state_d = roundOne;
    round_d = round_q + 4'd1;
    if (round_q <= 4'd10) begin
      state_d = roundTwo;
      round_d = round_q + 4'd2;
    end
  end
`else
  // One round per RUN cycle.
  always_comb begin
    state_d = roundOne;
    round_d = round_q + 4'd1;
  end
`endif

  // Control FSM: latch on start, iterate rounds, one writeback cycle, abort to idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q   <= AsconIdle;
      round_q <= 4'd0;
      state_q <= '0;
    end else begin
      case (fsm_q)
        AsconIdle: begin
          if (start_i && !abort_i) begin
            state_q <= state_i;
            round_q <= startRound;
            fsm_q   <= AsconRun;
          end
        end
        AsconRun: begin
          if (abort_i) begin
            fsm_q <= AsconIdle;
          end else begin
            state_q <= state_d;
            round_q <= round_d;
            if (round_d == 4'd12) fsm_q <= AsconWb;
          end
        end
        AsconWb: begin
          fsm_q <= AsconIdle;
        end
        default: begin
          fsm_q <= AsconIdle;
        end
      endcase
    end
  end

  // An abort in the writeback cycle suppresses the strobe in that same cycle.
  always_comb begin
    we_update_o = (fsm_q == AsconWb) && !abort_i;
    done_o      = we_update_o;
    busy_o      = (fsm_q != AsconIdle);
    state_o     = state_q;
  end

endmodule

// File: doc/ibex_ascon_perm_unit.md
# ibex_ascon_perm_unit

Sequential ASCON permutation engine on the register-file side of the ASCON port. When started, it captures the 320-bit state that the register file exposes on its ASCON read port and applies 1–12 ASCON rounds. It then returns the result through a one-cycle update strobe that the register file uses to overwrite its ten ASCON-mapped registers. It sits in the ID/EX stage beside the ALU, and the controller stalls the pipeline while the unit is busy.

## Interface
- DefaultRounds, 12: round count used when `rounds_i` is 0.
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- start_i  input  1  request a permutation; sampled only in IDLE.
- rounds_i  input  4  number of rounds n. Value 0 selects DefaultRounds; values above 12 clamp to 12.
- abort_i  input  1  flush; cancels the operation without writeback.
- state_i  input  ascon_state_t  current state; connects to the register-file ASCON read port.
- state_o  output  ascon_state_t  permuted state; connects to the register-file ASCON write port.
- we_update_o  output  1  writeback strobe; connects to the register-file update enable.
- busy_o  output  1  high whenever the FSM is not in IDLE.
- done_o  output  1  one-cycle completion pulse; equal to `we_update_o`.

## Operation
- FSM states: IDLE, RUN, WB.
- IDLE:
  - If `start_i` is high and `abort_i` is low, latch `state_i` into state_q.
  - Set round index r to 12−n, then go to RUN.
- RUN, on each clock edge:
  - Apply one round to state_q using constant c[r].
  - Increment r.
  - After the round with r=11 is applied, go to WB.
- WB:
  - Drive `we_update_o` = `done_o` = 1 and `state_o` = state_q for one cycle.
  - Go to IDLE.
- Round constants: c[0..11] = 0xf0, e1, d2, c3, b4, a5, 96, 87, 78, 69, 5a, 4b.
- Each round applies three steps in order:
  - Constant addition: x2 ^= c.
  - Bitsliced 5-bit S-box: x0^=x4; x4^=x3; x2^=x1; t_i=~x_i&x_{i+1 mod 5}; x_i^=t_{i+1 mod 5}; x1^=x0; x0^=x4; x3^=x2; x2=~x2.
  - Linear layer, as rotate-right amount pairs: x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41); each word becomes x ^ ror(x,a) ^ ror(x,b).
- All arithmetic is on 64-bit words.
  - Each word has bits 63:32 in `reg_view.x_hi` and bits 31:0 in `reg_view.x_low`.
  - x0..x4 map to register pairs x12/13, x14/15, x16/17, x28/29, x30/31.
- `state_o` always drives state_q. It is meaningful only while `we_update_o` is high.
- Boundary conditions:
  - `start_i` while busy is ignored and not queued.
  - `abort_i` in RUN: go to IDLE on the next edge, with no writeback.
  - `abort_i` in WB: `we_update_o` is forced low in that same cycle (`we_update_o` = WB & ~`abort_i`), then go to IDLE.
  - `start_i` and `abort_i` both high in IDLE: the start is ignored.
  - Reset mid-operation: return to IDLE with no writeback.
- The update strobe has priority over a simultaneous GPR write to the same register. The controller must hold off writes to the ASCON-mapped registers while `busy_o` is high.

## Timing
- Reset values: FSM=IDLE, r=0, state_q=0, `we_update_o`=0, `done_o`=0, `busy_o`=0, `state_o`=0.
- Cycle numbering: cycle 0 is the cycle in which `start_i` is accepted.
  - RUN occupies cycles 1..n.
  - WB, with `we_update_o` high, occurs in cycle n+1.
  - `busy_o` is high in cycles 1..n+1.
  - A new start can be accepted in cycle n+2.
- The register file captures `state_o` on the edge that ends cycle n+1.
- Without the unroll option, the p12 latency is 13 cycles from acceptance to strobe.

## Configuration
- Macro: `ASCON_PERM_UNROLL2_EN`.
- Defined:
  - RUN applies two chained rounds per edge (c[r], c[r+1]; r += 2) while at least 2 rounds remain.
  - When exactly 1 round remains, RUN applies a single round.
  - RUN lasts ceil(n/2) cycles and WB occurs in cycle ceil(n/2)+1.
- Undefined: one round per cycle, as specified above.
- The result is bit-identical in both builds.

## Structure
- `ibex_ascon_defines` package (shared) holds:
  - `ascon_state_t`
  - the round-constant array
  - the rotation-amount constants
  - FSM state enum `ascon_perm_state_e`
- Sub-module `ibex_ascon_round`: purely combinational single round.
  - Inputs: state, 8-bit constant. Output: state.
  - Instantiated once, or twice in series when `ASCON_PERM_UNROLL2_EN` is defined.

## Test plan
- Reset, then idle:
  - All outputs are 0.
  - `start_i` held low for 20 cycles → `busy_o` stays 0 and `we_update_o` is never asserted.
- All-zero state, `rounds_i`=1:
  - Strobe in cycle 2.
  - Result x4 = 0, x2 = ~x2 pre-linear path.
  - All five words match the software model, with constant 0x4b.
- ASCON-128 IV state (x0=0x80400c0600000000, key/nonce from KAT #1), `rounds_i`=0:
  - 12 rounds run and the strobe occurs in cycle 13 (7 with unroll).
  - Output matches the KAT after-init state before key XOR.
- `rounds_i`=6 and `rounds_i`=15:
  - 6 rounds use constants 0x96..0x4b.
  - 15 clamps to 12 rounds.
  - Latency is 7 and 13 cycles respectively.
- `start_i` re-asserted in cycles 1..n:
  - Ignored.
  - Exactly one strobe occurs.
  - Back-to-back start is accepted in cycle n+2.
- `abort_i` in RUN cycle 3 and, separately, in the WB cycle:
  - No `we_update_o` pulse.
  - IDLE on the next cycle.
  - The register-file ASCON registers are unchanged.
